// File: rtl/sync_fifo_pkg.sv
// Shared defaults, width formulas and data type for the single-clock FIFO.
// Any block that instantiates the FIFO should derive its widths from here.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 64;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the counter can hold DEPTH itself (full)
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_PTR_WIDTH = ptr_width(DEF_DEPTH);
  localparam int DEF_CNT_WIDTH = cnt_width(DEF_DEPTH);

  typedef logic [DEF_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
// master = the traffic source/sink, slave = the FIFO itself.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
);

  localparam int CNT_WIDTH = cnt_width(DEPTH);

  logic [DATA_WIDTH-1:0] buf_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] buf_out;
  logic                  buf_empty;
  logic                  buf_full;
  logic [CNT_WIDTH-1:0]  fifo_counter;

  modport master (
    output buf_in, wr_en, rd_en,
    input  buf_out, buf_empty, buf_full, fifo_counter
  );

  modport slave (
    input  buf_in, wr_en, rd_en,
    output buf_out, buf_empty, buf_full, fifo_counter
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH storage with one write port and one read port.
// Contents are never reset; the read value is registered by the parent.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int PTR_WIDTH  = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [PTR_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy counter, flags and registered read.
// Reads are not fall-through; buf_out updates only on an accepted read.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  sync_fifo_if.slave  bus
);

  localparam int CNT_WIDTH = cnt_width(DEPTH);
  localparam int PTR_WIDTH = ptr_width(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_out_q, buf_out_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty, full;
  logic                  wr_ok, rd_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_FULL);
  assign wr_ok = bus.wr_en && !full;
  assign rd_ok = bus.rd_en && !empty;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.buf_in),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    buf_out_d = buf_out_q;

    // Pointers are exactly log2(DEPTH) wide, so increment wraps on its own
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    end
    if (rd_ok) begin
      rd_ptr_d  = rd_ptr_q + PTR_WIDTH'(1);
      buf_out_d = rd_data;
    end

    case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
      2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      buf_out_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      buf_out_q <= buf_out_d;
    end
  end

  assign bus.buf_out      = buf_out_q;
  assign bus.buf_empty    = empty;
  assign bus.buf_full     = full;
  assign bus.fifo_counter = cnt_q;

  a_flags_exclusive: assert property (@(posedge clk) disable iff (rst) !(empty && full));
  a_cnt_bounded:     assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_FULL);

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: driver feeds a reference model and queues
// the expected per-cycle outputs; a monitor pops and compares after each edge.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DEPTH = 64;

  typedef struct {
    int cnt;
    int dout;
  } exp_t;

  logic clk;
  logic rst;

  sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(DEPTH)) bus ();

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   mdata[$];
  int   mcnt = 0;
  int   mout = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; model decides acceptance from its own occupancy
  task automatic cycle(input bit w, input bit r, input data_t din);
    bit   wa;
    bit   ra;
    exp_t e;
    @(negedge clk);
    bus.wr_en  = w;
    bus.rd_en  = r;
    bus.buf_in = din;
    wa = w && (mcnt < DEPTH);
    ra = r && (mcnt > 0);
    if (ra) mout = mdata.pop_front();
    if (wa) mdata.push_back(int'(din));
    mcnt = mcnt + int'(wa) - int'(ra);
    e.cnt  = mcnt;
    e.dout = mout;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 1 && mcnt > 0; k++) cycle(1'b0, 1'b1, 8'h00);
  endtask

  always @(posedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      #1;
      check("count", int'(bus.fifo_counter), e.cnt);
      check("empty", int'(bus.buf_empty), int'(e.cnt == 0));
      check("full",  int'(bus.buf_full),  int'(e.cnt == DEPTH));
      check("dout",  int'(bus.buf_out),   e.dout);
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    bus.wr_en  = 1'b0;
    bus.rd_en  = 1'b0;
    bus.buf_in = '0;
    #1;
    check("rst_count", int'(bus.fifo_counter), 0);
    check("rst_empty", int'(bus.buf_empty), 1);
    check("rst_full",  int'(bus.buf_full), 0);
    check("rst_dout",  int'(bus.buf_out), 0);
    #4;
    rst = 1'b0;

    // fill, overflow attempt, drain, underflow attempt
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, data_t'(i));
    cycle(1'b1, 1'b0, 8'hFF);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);

    // simultaneous read/write at count 10
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, data_t'(8'h10 + i));
    for (int i = 0; i < 5; i++)  cycle(1'b1, 1'b1, data_t'(8'hA0 + i));
    drain();

    // both requests while full, then while empty
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, data_t'(8'hC0 ^ i));
    cycle(1'b1, 1'b1, 8'h77);
    drain();
    cycle(1'b1, 1'b1, 8'hAB);
    cycle(1'b0, 1'b1, 8'h00);

    // interleaved traffic keeping occupancy at 3..4 so pointers wrap
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, data_t'(8'hE0 + i));
    for (int i = 0; i < 100; i++)
      cycle((i % 3) != 2, (i % 3) != 0, data_t'(8'h20 + i));
    drain();

    // asynchronous reset in the middle of a cycle at count 20
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, data_t'(8'h80 + i));
    settle();
    check("pre_rst_count", int'(bus.fifo_counter), mcnt);
    #2;
    rst = 1'b1;
    #1;
    check("async_count", int'(bus.fifo_counter), 0);
    check("async_empty", int'(bus.buf_empty), 1);
    check("async_full",  int'(bus.buf_full), 0);
    check("async_dout",  int'(bus.buf_out), 0);
    #1;
    rst = 1'b0;
    mdata.delete();
    mcnt = 0;
    mout = 0;

    cycle(1'b1, 1'b0, 8'h5A);
    cycle(1'b0, 1'b1, 8'h00);
    settle();
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
